// File: rtl/branch_predictor.sv
// Dynamic branch predictor: PC-indexed saturating-counter table, optional gshare history, init FSM, stats.
// Latency: prediction is combinational; table/ghr/stats update on the posedge after check_valid.
// Backpressure: none on the datapath; ready is low while the table initialises and updates are ignored.
module branch_predictor #(
    parameter int ENTRIES  = 32,
    parameter int CNT_BITS = 2,
    parameter int GHR_BITS = 0,
    parameter int PC_LSB   = 2,
    localparam int IDX     = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bp_enable,
    input  logic            guess_valid,
    input  logic [31:0]     guess_pc,
    output logic            guess_taken,
    output logic [IDX-1:0]  guess_idx,
    input  logic            check_valid,
    input  logic [IDX-1:0]  check_idx,
    input  logic            check_taken,
    input  logic            check_pred,
    output logic            mispredict,
    output logic            ready,
    input  logic            stats_clr,
    output logic [31:0]     n_branches,
    output logic [31:0]     n_mispredicts
);

    // History register is kept at least one bit wide so bimodal builds have no zero-width vectors.
    localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CNT_BITS-1:0] WNT     = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_MIN = '0;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [IDX-1:0]      init_ptr;
    logic                ready_q;
    logic [CNT_BITS-1:0] table_q [ENTRIES];
    logic [GW-1:0]       ghr;
    logic [IDX-1:0]      ghr_ext;
    logic [CNT_BITS-1:0] cur_cnt;
    logic [CNT_BITS-1:0] nxt_cnt;
    logic                upd_en;
    logic [31:0]         br_cnt;
    logic [31:0]         mis_cnt;
    logic                unused_pc;

    // Only the index field of the PC is consumed.
    assign unused_pc = ^guess_pc;

    // Training is allowed only once the table holds valid counters.
    assign upd_en = rst_n && (state == S_RUN) && check_valid;

    // Init FSM: walk the table once after reset, then stay in RUN; ready is registered with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_ptr <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == IDX'(ENTRIES - 1)) begin
                        state   <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= S_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;

    // Saturating step of the counter being resolved; holds at either end instead of wrapping.
    always_comb begin
        cur_cnt = table_q[check_idx];
        nxt_cnt = cur_cnt;
        if (check_taken) begin
            if (cur_cnt != CNT_MAX) nxt_cnt = cur_cnt + 1'b1;
        end else begin
            if (cur_cnt != CNT_MIN) nxt_cnt = cur_cnt - 1'b1;
        end
    end

    // Counter table: seeded to weakly-not-taken during INIT, trained by resolved branches in RUN.
    always_ff @(posedge clk) begin
        if (rst_n && state == S_INIT) begin
            table_q[init_ptr] <= WNT;
        end else if (upd_en) begin
            table_q[check_idx] <= nxt_cnt;
        end
    end

    // Global history holds resolved (non-speculative) outcomes, newest in bit 0.
    generate
        if (GHR_BITS == 0) begin : g_no_ghr
            assign ghr = '0;
        end else if (GHR_BITS == 1) begin : g_ghr1
            always_ff @(posedge clk) begin
                if (!rst_n) ghr <= '0;
                else if (upd_en) ghr <= check_taken;
            end
        end else begin : g_ghrn
            always_ff @(posedge clk) begin
                if (!rst_n) ghr <= '0;
                else if (upd_en) ghr <= {ghr[GW-2:0], check_taken};
            end
        end
    endgenerate

    // History zero-extended into the index LSBs; all zero in bimodal mode.
    always_comb begin
        ghr_ext = '0;
        if (GHR_BITS > 0) ghr_ext[GW-1:0] = ghr;
    end

    // Prediction reads the pre-update table and history, so a same-cycle check is not visible yet.
    assign guess_idx   = guess_pc[PC_LSB +: IDX] ^ ghr_ext;
    assign guess_taken = ready_q & bp_enable & guess_valid & table_q[guess_idx][CNT_BITS-1];

    assign mispredict = check_valid & (check_taken ^ check_pred);

    // Statistics: count in RUN only; a clear in the same cycle as an increment wins.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (upd_en) begin
            br_cnt <= br_cnt + 32'd1;
            if (mispredict) mis_cnt <= mis_cnt + 32'd1;
        end
    end

    assign n_branches    = br_cnt;
    assign n_mispredicts = mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a bimodal and a gshare instance share the stimulus.
// Stimulus pushes expected values after each posedge; a negedge monitor pops and compares them.
// Never stalls on the DUT; a watchdog bounds the run.
module tb_branch_predictor;

    localparam int F_TKB = 0, F_IDXB = 1, F_MISB = 2, F_RDYB = 3, F_NBRB = 4, F_NMISB = 5;
    localparam int F_TKG = 6, F_IDXG = 7, F_MISG = 8, F_RDYG = 9, F_NBRG = 10, F_NMISG = 11;

    typedef struct {
        int          field;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        bp_enable;
    logic        guess_valid;
    logic [31:0] guess_pc;
    logic        check_valid;
    logic [4:0]  check_idx;
    logic        check_taken;
    logic        check_pred;
    logic        stats_clr;

    logic        b_taken, b_mis, b_ready;
    logic [4:0]  b_idx;
    logic [31:0] b_nbr, b_nmis;
    logic        g_taken, g_mis, g_ready;
    logic [4:0]  g_idx;
    logic [31:0] g_nbr, g_nmis;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    branch_predictor #(.ENTRIES(32), .CNT_BITS(2), .GHR_BITS(0), .PC_LSB(2)) u_bim (
        .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable),
        .guess_valid(guess_valid), .guess_pc(guess_pc),
        .guess_taken(b_taken), .guess_idx(b_idx),
        .check_valid(check_valid), .check_idx(check_idx),
        .check_taken(check_taken), .check_pred(check_pred),
        .mispredict(b_mis), .ready(b_ready), .stats_clr(stats_clr),
        .n_branches(b_nbr), .n_mispredicts(b_nmis)
    );

    branch_predictor #(.ENTRIES(32), .CNT_BITS(2), .GHR_BITS(4), .PC_LSB(2)) u_gsh (
        .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable),
        .guess_valid(guess_valid), .guess_pc(guess_pc),
        .guess_taken(g_taken), .guess_idx(g_idx),
        .check_valid(check_valid), .check_idx(check_idx),
        .check_taken(check_taken), .check_pred(check_pred),
        .mispredict(g_mis), .ready(g_ready), .stats_clr(stats_clr),
        .n_branches(g_nbr), .n_mispredicts(g_nmis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, pending=%0d required=0", sb.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: every expectation queued during this cycle is compared at the falling edge.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.field)
                F_TKB:   mon_act = {31'd0, b_taken};
                F_IDXB:  mon_act = {27'd0, b_idx};
                F_MISB:  mon_act = {31'd0, b_mis};
                F_RDYB:  mon_act = {31'd0, b_ready};
                F_NBRB:  mon_act = b_nbr;
                F_NMISB: mon_act = b_nmis;
                F_TKG:   mon_act = {31'd0, g_taken};
                F_IDXG:  mon_act = {27'd0, g_idx};
                F_MISG:  mon_act = {31'd0, g_mis};
                F_RDYG:  mon_act = {31'd0, g_ready};
                F_NBRG:  mon_act = g_nbr;
                default: mon_act = g_nmis;
            endcase
            n_chk++;
            if (mon_act === mon_e.val) n_pass++;
            else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", mon_e.name, mon_act, mon_e.val, $time);
        end
    end

    task automatic push_exp(input int f, input logic [31:0] v, input string n);
        exp_t e;
        e.field = f;
        e.val   = v;
        e.name  = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Resolve a branch this cycle on both instances; the mispredict flag is combinational.
    task automatic chk(input logic [4:0] idx, input logic t, input logic p);
        check_valid = 1'b1;
        check_idx   = idx;
        check_taken = t;
        check_pred  = p;
        push_exp(F_MISB, {31'd0, t ^ p}, "mispredict_b");
        push_exp(F_MISG, {31'd0, t ^ p}, "mispredict_g");
    endtask

    task automatic probe(input logic [31:0] pc);
        check_valid = 1'b0;
        guess_pc    = pc;
    endtask

    // Release reset (already low) and watch the 32-cycle table walk.
    task automatic init_walk(input string tag);
        rst_n = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i > 0) step();
            guess_pc    = 32'h100 + 32'(i * 4);
            check_valid = (i == 5);
            check_idx   = 5'd0;
            check_taken = 1'b1;
            check_pred  = 1'b0;
            push_exp(F_RDYB, {31'd0, i == 32}, {tag, "_ready_b"});
            push_exp(F_RDYG, {31'd0, i == 32}, {tag, "_ready_g"});
            push_exp(F_TKB, 32'd0, {tag, "_taken_b"});
            push_exp(F_TKG, 32'd0, {tag, "_taken_g"});
            if (i == 5) push_exp(F_MISB, 32'd1, {tag, "_mis_comb"});
            if (i == 6) push_exp(F_NBRB, 32'd0, {tag, "_nbr_frozen"});
        end
        check_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bp_enable = 1'b1; guess_valid = 1'b1; guess_pc = 32'h100;
        check_valid = 1'b0; check_idx = '0; check_taken = 1'b0; check_pred = 1'b0; stats_clr = 1'b0;

        repeat (3) step();
        push_exp(F_RDYB, 32'd0, "rst_ready");
        push_exp(F_NBRB, 32'd0, "rst_nbr");
        push_exp(F_NMISB, 32'd0, "rst_nmis");
        push_exp(F_TKB, 32'd0, "rst_taken");
        step();
        init_walk("init");
        push_exp(F_IDXB, 32'd0, "alias_0x180_during_init");

        // Bimodal training on PC 0x100 (index 0), starting from WNT = 1.
        step(); probe(32'h100); chk(5'd0, 1'b1, 1'b0);
        push_exp(F_TKB, 32'd0, "train_pre");
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd1, "train_t1");
        push_exp(F_NBRB, 32'd1, "train_nbr1");
        push_exp(F_NMISB, 32'd1, "train_nmis1");
        repeat (5) begin step(); chk(5'd0, 1'b1, 1'b1); end
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd1, "train_t6");
        push_exp(F_NBRB, 32'd6, "train_nbr6");
        step(); chk(5'd0, 1'b0, 1'b1);
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd1, "train_nt1");
        push_exp(F_NMISB, 32'd2, "train_nmis2");
        repeat (2) begin step(); chk(5'd0, 1'b0, 1'b1); end
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd0, "train_nt3");
        push_exp(F_NBRB, 32'd9, "train_nbr9");
        step(); chk(5'd0, 1'b0, 1'b0);
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd0, "train_floor");
        push_exp(F_NMISB, 32'd4, "train_nmis4");
        step(); chk(5'd0, 1'b1, 1'b0);
        step(); probe(32'h100);
        push_exp(F_TKB, 32'd0, "train_from_floor");
        step(); chk(5'd0, 1'b1, 1'b0);
        step(); probe(32'h180);
        push_exp(F_TKB, 32'd1, "alias_taken");
        push_exp(F_IDXB, 32'd0, "alias_idx");
        push_exp(F_NBRB, 32'd12, "train_nbr12");
        push_exp(F_NMISB, 32'd6, "train_nmis6");
        step(); probe(32'h100); guess_valid = 1'b0;
        push_exp(F_TKB, 32'd0, "guess_valid_low");

        // Read-before-write on index 3 (PC 0x10C).
        step(); guess_valid = 1'b1; guess_pc = 32'h10C; chk(5'd3, 1'b1, 1'b0);
        push_exp(F_TKB, 32'd0, "rbw_same_cycle");
        push_exp(F_IDXB, 32'd3, "rbw_idx");
        step(); probe(32'h10C);
        push_exp(F_TKB, 32'd1, "rbw_next_cycle");

        // bp_enable low: static not-taken, training and stats continue.
        step(); guess_pc = 32'h100; chk(5'd0, 1'b1, 1'b1);
        step(); probe(32'h100); bp_enable = 1'b0;
        push_exp(F_TKB, 32'd0, "bpen_off_saturated");
        step(); chk(5'd0, 1'b0, 1'b1);
        step(); chk(5'd0, 1'b0, 1'b1);
        step(); probe(32'h100); bp_enable = 1'b1;
        push_exp(F_TKB, 32'd0, "bpen_trained_while_off");
        push_exp(F_NBRB, 32'd16, "bpen_nbr");
        push_exp(F_NMISB, 32'd9, "bpen_nmis");

        // Mispredict counter wrap, then clear racing an increment.
        step(); probe(32'h100);
        force u_bim.mis_cnt = 32'hFFFF_FFFF;
        #1;
        release u_bim.mis_cnt;
        push_exp(F_NMISB, 32'hFFFF_FFFF, "nmis_preload");
        step(); chk(5'd0, 1'b1, 1'b0);
        step(); probe(32'h100);
        push_exp(F_NMISB, 32'd0, "nmis_wrap");
        push_exp(F_NBRB, 32'd17, "nbr_at_wrap");
        step(); chk(5'd0, 1'b1, 1'b0); stats_clr = 1'b1;
        step(); probe(32'h100); stats_clr = 1'b0;
        push_exp(F_NBRB, 32'd0, "clr_wins_nbr");
        push_exp(F_NMISB, 32'd0, "clr_wins_nmis");
        step(); chk(5'd0, 1'b1, 1'b0);
        step(); probe(32'h100);
        push_exp(F_NBRB, 32'd1, "clr_resume_nbr");
        push_exp(F_NMISB, 32'd1, "clr_resume_nmis");

        // Reset again, abort INIT at pointer 10, and expect a full restart.
        step(); rst_n = 1'b0;
        step();
        push_exp(F_RDYB, 32'd0, "rst2_ready");
        push_exp(F_NBRB, 32'd0, "rst2_nbr");
        step(); rst_n = 1'b1;
        repeat (10) step();
        push_exp(F_RDYB, 32'd0, "mid_init_ready");
        rst_n = 1'b0;
        step();
        init_walk("reinit");
        step(); probe(32'h10C);
        push_exp(F_TKB, 32'd0, "reinit_entry3");

        // Gshare: outcomes 1,0,1,0 build ghr = 4'b1010.
        step(); chk(5'd31, 1'b1, 1'b0);
        step(); chk(5'd31, 1'b0, 1'b0);
        step(); chk(5'd31, 1'b1, 1'b0);
        step(); chk(5'd31, 1'b0, 1'b0);
        step(); probe(32'h100);
        push_exp(F_IDXG, 32'h0A, "gsh_idx_0x100");
        push_exp(F_IDXB, 32'h00, "bim_idx_0x100");
        push_exp(F_TKG, 32'd0, "gsh_taken_wnt");
        step(); probe(32'h180);
        push_exp(F_IDXG, 32'h0A, "gsh_idx_0x180");
        step(); guess_pc = 32'h100; chk(5'd10, 1'b1, 1'b0);
        push_exp(F_IDXG, 32'h0A, "gsh_idx_pre_update");
        step(); probe(32'h13C);
        push_exp(F_IDXG, 32'h0A, "gsh_idx_ghr0101");
        push_exp(F_TKG, 32'd1, "gsh_taken_trained");
        push_exp(F_IDXB, 32'h0F, "bim_idx_0x13c");
        push_exp(F_TKB, 32'd0, "bim_taken_0x13c");
        step(); guess_pc = 32'h13C; chk(5'd31, 1'b1, 1'b1);
        push_exp(F_IDXG, 32'h0A, "gsh_idx_same_cycle");
        step(); probe(32'h13C);
        push_exp(F_IDXG, 32'h04, "gsh_idx_ghr1011");
        push_exp(F_NBRB, 32'd6, "end_nbr_b");
        push_exp(F_NBRG, 32'd6, "end_nbr_g");
        push_exp(F_NMISG, 32'd3, "end_nmis_g");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard: pending=%0d required=0", sb.size());
            $fatal(1, "scoreboard not drained");
        end
        if (n_chk < 12) begin
            $display("FAIL coverage: checks=%0d required>=12", n_chk);
            $fatal(1, "too few checks");
        end
        if (n_pass != n_chk) begin
            $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
            $fatal(1, "checks failed");
        end
        $display("PASS");
        $finish;
    end

endmodule
